// File: rtl/fetch_queue.sv
// IF->ID instruction fetch queue: DEPTH-entry circular FIFO with valid/allow handshake,
// single-cycle flush and an optional zero-latency bypass when empty.
module fetch_queue #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4,
  parameter bit BYPASS = 1'b1
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     in_allow,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  input  logic                     out_allow,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     rp;
  logic [PW-1:0]     wp;
  logic [CW-1:0]     count_q;

  logic bypass_sel;
  logic push;
  logic pop;
  logic pass_thru;
  logic wr_en;
  logic rd_en;

  assign count = count_q;
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  assign bypass_sel = BYPASS && empty;

  // in_allow deliberately ignores out_allow so ID never reaches back into IF combinationally.
  assign in_allow  = resetn && !flush && !full;
  assign out_valid = resetn && !flush && (!empty || (bypass_sel && in_valid));
  assign out_data  = bypass_sel ? in_data : mem[rp];

  assign push      = in_valid && in_allow;
  assign pop       = out_valid && out_allow && !flush;
  assign pass_thru = bypass_sel && push && pop;
  assign wr_en     = push && !pass_thru;
  assign rd_en     = pop && !empty;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wp] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rp      <= '0;
      wp      <= '0;
      count_q <= '0;
    end else if (flush) begin
      rp      <= '0;
      wp      <= '0;
      count_q <= '0;
    end else begin
      if (wr_en) begin
        wp <= wp + PW'(1);
      end
      if (rd_en) begin
        rp <= rp + PW'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: queue-based scoreboard model, a vector table for fill/drain,
// and hand-written sequences for streaming, bypass, flush, full+pop and async reset.
module tb_fetch_queue;

  localparam int DATA_W = 64;
  localparam int DEPTH  = 4;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic              clk;
  logic              resetn;
  logic              flush;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_allow;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_allow;
  logic [CW-1:0]     count;
  logic              full;
  logic              empty;

  logic              b_flush;
  logic              b_in_valid;
  logic [DATA_W-1:0] b_in_data;
  logic              b_in_allow;
  logic              b_out_valid;
  logic [DATA_W-1:0] b_out_data;
  logic              b_out_allow;
  logic [CW-1:0]     b_count;
  logic              b_full;
  logic              b_empty;

  fetch_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH), .BYPASS(1'b1)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_allow(in_allow),
    .out_valid(out_valid), .out_data(out_data), .out_allow(out_allow),
    .count(count), .full(full), .empty(empty)
  );

  fetch_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH), .BYPASS(1'b0)) dut_nb (
    .clk(clk), .resetn(resetn), .flush(b_flush),
    .in_valid(b_in_valid), .in_data(b_in_data), .in_allow(b_in_allow),
    .out_valid(b_out_valid), .out_data(b_out_data), .out_allow(b_out_allow),
    .count(b_count), .full(b_full), .empty(b_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [DATA_W-1:0] sb[$];

  typedef struct {
    logic              iv;
    logic [DATA_W-1:0] d;
    logic              oa;
    logic              fl;
    logic              exp_valid;
    logic              exp_allow;
    int                exp_count;
  } vec_t;

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle on the BYPASS=1 instance: drive at negedge, compare against the model,
  // advance the model, then move to the next negedge.
  task automatic step(input logic iv, input logic [DATA_W-1:0] d, input logic oa, input logic fl);
    logic m_allow, m_valid;
    logic [DATA_W-1:0] m_data;
    in_valid = iv; in_data = d; out_allow = oa; flush = fl;
    #1;
    m_allow = resetn && !fl && (sb.size() < DEPTH);
    m_valid = resetn && !fl && ((sb.size() > 0) || iv);
    m_data  = (sb.size() > 0) ? sb[0] : d;
    chk("in_allow", 64'(in_allow), 64'(m_allow));
    chk("out_valid", 64'(out_valid), 64'(m_valid));
    chk("count", 64'(count), 64'(sb.size()));
    chk("full", 64'(full), 64'(sb.size() == DEPTH));
    chk("empty", 64'(empty), 64'(sb.size() == 0));
    if (m_valid && oa) chk("out_data", out_data, m_data);
    if (iv && m_allow) sb.push_back(d);
    if (m_valid && oa) void'(sb.pop_front());
    if (fl) sb.delete();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 1; i++) step(1'b0, '0, 1'b1, 1'b0);
  endtask

  vec_t vt[11];

  initial begin
    vt[0]  = '{1'b1, 64'h1,  1'b0, 1'b0, 1'b1, 1'b1, 0};
    vt[1]  = '{1'b1, 64'h2,  1'b0, 1'b0, 1'b1, 1'b1, 1};
    vt[2]  = '{1'b1, 64'h3,  1'b0, 1'b0, 1'b1, 1'b1, 2};
    vt[3]  = '{1'b1, 64'h4,  1'b0, 1'b0, 1'b1, 1'b1, 3};
    vt[4]  = '{1'b1, 64'h99, 1'b0, 1'b0, 1'b1, 1'b0, 4};
    vt[5]  = '{1'b0, 64'h0,  1'b1, 1'b0, 1'b1, 1'b0, 4};
    vt[6]  = '{1'b0, 64'h0,  1'b1, 1'b0, 1'b1, 1'b1, 3};
    vt[7]  = '{1'b0, 64'h0,  1'b1, 1'b0, 1'b1, 1'b1, 2};
    vt[8]  = '{1'b0, 64'h0,  1'b1, 1'b0, 1'b1, 1'b1, 1};
    vt[9]  = '{1'b0, 64'h0,  1'b0, 1'b0, 1'b0, 1'b1, 0};
    vt[10] = '{1'b0, 64'h0,  1'b1, 1'b0, 1'b0, 1'b1, 0};

    resetn = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 64'h5; out_allow = 1'b1;
    b_flush = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_out_allow = 1'b0;
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_allow", 64'(in_allow), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full", 64'(full), 64'd0);
    @(negedge clk);
    in_valid = 1'b0;
    resetn = 1'b1;
    #1;
    chk("post_rst_out_valid", 64'(out_valid), 64'd0);
    chk("post_rst_count", 64'(count), 64'd0);
    @(negedge clk);

    // Fill to full with out_allow low, reject an extra push, then drain in order.
    for (int i = 0; i < 11; i++) begin
      in_valid = vt[i].iv; in_data = vt[i].d; out_allow = vt[i].oa; flush = vt[i].fl;
      #1;
      chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'(vt[i].exp_valid));
      chk($sformatf("vec%0d_allow", i), 64'(in_allow), 64'(vt[i].exp_allow));
      chk($sformatf("vec%0d_count", i), 64'(count), 64'(vt[i].exp_count));
      #0;
      step(vt[i].iv, vt[i].d, vt[i].oa, vt[i].fl);
    end

    // Streaming at count=2 for 20 cycles; pointers wrap repeatedly.
    step(1'b1, 64'h100, 1'b0, 1'b0);
    step(1'b1, 64'h101, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 64'h102 + 64'(i), 1'b1, 1'b0);
      chk("stream_count", 64'(count), 64'd2);
    end
    drain();

    // Bypass pass-through: same-cycle output, count stays 0.
    in_valid = 1'b1; in_data = 64'hABCD; out_allow = 1'b1;
    #1;
    chk("byp_valid", 64'(out_valid), 64'd1);
    chk("byp_data", out_data, 64'hABCD);
    step(1'b1, 64'hABCD, 1'b1, 1'b0);
    chk("byp_count", 64'(count), 64'd0);

    // Non-bypass instance: output one cycle after push.
    b_in_valid = 1'b1; b_in_data = 64'hABCD; b_out_allow = 1'b1;
    #1;
    chk("nb_valid0", 64'(b_out_valid), 64'd0);
    @(posedge clk); @(negedge clk);
    b_in_valid = 1'b0;
    #1;
    chk("nb_valid1", 64'(b_out_valid), 64'd1);
    chk("nb_data1", b_out_data, 64'hABCD);
    chk("nb_count1", 64'(b_count), 64'd1);
    @(posedge clk); @(negedge clk);
    chk("nb_count2", 64'(b_count), 64'd0);
    b_out_allow = 1'b0;

    // Flush with 3 entries while in_valid and out_allow are high.
    for (int i = 0; i < 3; i++) step(1'b1, 64'h30 + 64'(i), 1'b0, 1'b0);
    in_valid = 1'b1; in_data = 64'h3F; out_allow = 1'b1; flush = 1'b1;
    #1;
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_allow", 64'(in_allow), 64'd0);
    step(1'b1, 64'h3F, 1'b1, 1'b1);
    chk("postflush_count", 64'(count), 64'd0);
    chk("postflush_empty", 64'(empty), 64'd1);
    step(1'b1, 64'h55, 1'b0, 1'b0);
    chk("first_after_flush", out_data, 64'h55);
    step(1'b0, '0, 1'b1, 1'b0);

    // Full with push and pop offered: only the pop happens.
    for (int i = 0; i < 4; i++) step(1'b1, 64'h70 + 64'(i), 1'b0, 1'b0);
    step(1'b1, 64'h77, 1'b1, 1'b0);
    chk("fullpop_count", 64'(count), 64'd3);
    step(1'b1, 64'h77, 1'b0, 1'b0);
    chk("refill_count", 64'(count), 64'd4);
    drain();

    // Asynchronous reset between edges with 3 entries queued.
    for (int i = 0; i < 3; i++) step(1'b1, 64'hA0 + 64'(i), 1'b0, 1'b0);
    in_valid = 1'b1; in_data = 64'hEE; out_allow = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_allow", 64'(in_allow), 64'd0);
    chk("arst_empty", 64'(empty), 64'd1);
    sb.delete();
    @(negedge clk);
    resetn = 1'b1;
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 64'hBB, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1);
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction fetch queue that sits between IF and ID, replacing the single-entry IF/ID pipeline register with a DEPTH-entry FIFO. It uses the pipeline's valid/allow_in handshake on both sides, so IF can keep fetching while ID is stalled on a load-use hazard. A branch-cancel flush discards every queued entry in one cycle. An optional bypass path gives an empty queue zero-cycle latency.

## Interface
- DATA_W, 64, payload width; normally {pc[31:0], inst[31:0]}.
- DEPTH, 4, number of entries; a power of two and at least 2.
- BYPASS, 1, when 1 an empty queue forwards its input combinationally to its output; when 0 every entry is registered.

- clk  in  1  clock; all state updates on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous discard of all entries (driven by br_taken_cancel).
- in_valid  in  1  IF presents a valid payload.
- in_data  in  DATA_W  IF payload.
- in_allow  out  1  queue accepts a push this cycle.
- out_valid  out  1  a payload is presented to ID.
- out_data  out  DATA_W  payload to ID.
- out_allow  in  1  ID accepts a payload (ds_allow_in).
- count  out  $clog2(DEPTH)+1  number of stored entries.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

## Operation
- Storage is a circular buffer with read pointer rp and write pointer wp, each $clog2(DEPTH) bits and wrapping modulo DEPTH, plus count.
- Handshake:
  - push = in_valid && in_allow.
  - pop = out_valid && out_allow && !flush.
  - in_allow = resetn && !flush && !full. It does not depend on out_allow, so there is no combinational path from ID back to IF.
- Registered path (count > 0):
  - out_valid = 1; out_data = mem[rp].
  - On pop, rp advances by 1.
- Bypass path (BYPASS=1 and count == 0):
  - out_valid = in_valid && !flush; out_data = in_data.
  - If out_allow is 1 in the same cycle, the payload passes straight through: nothing is written, and count and pointers are unchanged.
  - If out_allow is 0, the payload is written to mem[wp], wp advances, and count becomes 1.
- With BYPASS=0 and count == 0: out_valid = 0, and out_data holds mem[rp] but has no meaning.
- Push with no bypass pass-through: mem[wp] <= in_data, wp advances.
- count update:
  - +1 on push without pop.
  - -1 on pop without push.
  - unchanged on push with pop, or on a bypass pass-through.
- Full and pop in the same cycle: in_allow = 0, so only the pop happens and count = DEPTH-1 next cycle.
- Flush takes priority over everything. On the next edge rp, wp and count go to 0. During the flush cycle no push or pop occurs and out_valid = 0.
- Reset (asynchronous, on resetn low): rp, wp and count go to 0. Memory contents are not reset.

## Timing
- Output values while in reset and on the cycle after reset release: out_valid = 0, count = 0, empty = 1, full = 0, in_allow = 0 while resetn is low.
- Latency from push to out_valid:
  - 0 cycles with BYPASS=1 and an empty queue.
  - 1 cycle otherwise (the payload is visible from the edge after the push).
- Throughput is 1 push and 1 pop per cycle, sustained, whenever count is between 1 and DEPTH-1.
- flush asserted on edge N: the first new push is accepted in cycle N+1, where in_allow = 1.
- Pointer wrap: after DEPTH pushes without any pops, wp returns to rp and full = 1. Ordering stays strict FIFO across the wrap.
- resetn asserted in the middle of traffic: the queue empties immediately. A payload being pushed in that cycle is lost.

## Test plan
- Reset, then DEPTH=4 with out_allow=0: push payloads 0x1..0x4. Expect full=1, in_allow=0, count=4. Then pull out_allow=1 for 4 cycles: out_data must be 1,2,3,4 in order, and empty=1 afterwards.
- Continuous streaming with count=2, in_valid=1 and out_allow=1 for 20 cycles, payloads incrementing from 0x100. Expect count to stay at 2, in-order output, and both pointers to wrap 5 times.
- BYPASS=1, empty queue, in_valid=1, in_data=0xABCD, out_allow=1. Expect out_valid=1 and out_data=0xABCD in the same cycle, with count staying 0. Repeat with BYPASS=0: output appears one cycle later.
- Fill to 3 entries, then assert flush with in_valid=1 and out_allow=1 in the same cycle. Expect out_valid=0 and in_allow=0 that cycle; next cycle count=0 and empty=1; the next push of 0x55 is output as the first item.
- Full queue with out_allow=1 and in_valid=1. Expect a pop but no push (count drops 4→3), then a push is accepted on the following cycle.
- Assert resetn=0 asynchronously between clock edges while count=3. Expect count=0 and out_valid=0 immediately, before the next clk edge.
